garage_input_conditioner: RTL and testbench
===========================================

Name: garage_input_conditioner

Overview:
- Front-end stage directly upstream of the garage door FSM.
- Synchronizes and debounces the raw remote button into a one-cycle `remote` pulse.
- Synchronizes the open and closed limit sensors.
- Generates the one-cycle 30 s auto-close `timer` pulse while the door sits open. All outputs feed the FSM's `remote`/`open`/`closed`/`timer` inputs on the same `clk`.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples needed to accept a press or release (10 ms @ 50 MHz); must be >= 2.
- TIMEOUT_CYCLES, 1500000000: cycles of continuous `open` before `timer` fires (30 s @ 50 MHz); must be >= 2.
- CNT_W, 32: width of the debounce and timeout counters; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- remote_raw  input  1  raw push button, asynchronous, bouncy, 1 = pressed
- open_raw  input  1  raw open limit switch, asynchronous, 1 = door fully open
- closed_raw  input  1  raw closed limit switch, asynchronous, 1 = door fully closed
- remote  output  1  registered one-cycle pulse per accepted press
- open  output  1  registered synchronized open sensor
- closed  output  1  registered synchronized closed sensor
- timer  output  1  registered one-cycle auto-close pulse

Behaviour:

Reset and synchronizers
- Reset is asynchronous, active-low: clk, rst_n (async active-low).
- While rst_n=0: all outputs, synchronizer flops and counters are 0; debounce FSM is in IDLE; timeout `fired` flag is 0.
- Deassertion takes effect on the first clk edge with rst_n=1.
- Each raw input passes a 2-flop synchronizer (`*_s`). All logic uses `*_s` only.
- `open` and `closed` are registered copies of `open_s`/`closed_s`: 3 edges from raw change to output change.

Debounce FSM (on `remote_s`, counter `dcnt`)
- IDLE: if remote_s=1, go to PRESS_WAIT with dcnt=0.
- PRESS_WAIT:
  - remote_s=0: go to IDLE.
  - Otherwise dcnt++.
  - When dcnt==DEBOUNCE_CYCLES-1 and remote_s=1: go to HELD, and `remote` is 1 for the next cycle only.
- HELD: if remote_s=0, go to RELEASE_WAIT with dcnt=0. No further pulses while held, regardless of hold length.
- RELEASE_WAIT:
  - remote_s=1: go to HELD.
  - Otherwise dcnt++.
  - When dcnt==DEBOUNCE_CYCLES-1: go to IDLE.
- Latency: with a clean press first sampled high at edge 1, `remote` is high during the cycle after edge DEBOUNCE_CYCLES+3, and for exactly 1 cycle.
- Glitches shorter than DEBOUNCE_CYCLES samples produce no pulse.
- Illegal state encodings recover to IDLE.

Auto-close timeout (counter `tcnt`, flag `fired`)
- When `open`=0: tcnt=0 and fired=0.
- When `open`=1 and fired=0: tcnt++. When tcnt==TIMEOUT_CYCLES-1: timer=1 the next cycle, fired=1, tcnt holds.
- When `open`=1 and fired=1: no further pulses. `timer` re-arms only after `open` drops.
- Simultaneous `remote` pulse and `open`=1: tcnt=0 and fired=0 (a press restarts the 30 s window). A remote pulse in the same cycle the terminal count is reached wins: no timer pulse.
- `timer` and `remote` may never be high in the same cycle.
- Counters are CNT_W bits unsigned. tcnt never wraps; it saturates at TIMEOUT_CYCLES-1.

Reset mid-operation
- Asserting rst_n during PRESS_WAIT or mid-timeout aborts immediately. No pulse is emitted after release of reset until conditions are re-met from scratch.

Optional Feature:
Macro SENSOR_FILTER_EN.
- Defined:
  - `open` and `closed` each pass a 3-sample majority/stability filter after the synchronizer.
  - An output changes only after 3 consecutive equal `*_s` samples, so latency from raw change to output change is 5 edges.
  - Single-cycle sensor glitches are suppressed.
- Not defined: plain registered synchronizer path, 3-edge latency. Debounce and timeout logic are identical in both builds.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=10.
1. Reset then clean press: remote_raw=1 held 40 cycles -> exactly one `remote` pulse, high during the cycle after edge 7; `remote` stays 0 for the remaining hold and after release.
2. Bounce: remote_raw toggles 1,0,1,1,0,1,1,1,1 then holds 1 -> no pulse until 4 consecutive synchronized highs, then exactly one pulse. A 3-cycle glitch alone -> no pulse.
3. Timeout: open_raw=1 held 30 cycles -> `open`=1 at edge 3; `timer` pulses once, 10 cycles after `open` rose; no second pulse. Drop open_raw for 5 cycles, reassert -> pulse again 10 cycles after `open` returns.
4. Restart: open held, remote press accepted 6 cycles into the window -> tcnt cleared; `timer` fires 10 cycles after the remote pulse, never in the same cycle as it.
5. Async reset: rst_n=0 mid PRESS_WAIT (dcnt=2) and at tcnt=8 -> all outputs 0 immediately, without a clock edge; after release with inputs still high, full latencies restart (remote at +7, timer +10 after `open`).
6. SENSOR_FILTER_EN build: 1-cycle closed_raw glitch -> `closed` unchanged. Sustained change -> `closed` follows 5 edges later. Non-filtered build: 3 edges, and the glitch propagates.

Source files
------------

// File: rtl/garage_input_conditioner_if.sv
// Signal bundle between the raw garage inputs, the conditioner and the door FSM.
// The conditioner drives the slave side; whoever supplies raw inputs holds the master side.
`timescale 1ns/1ps

interface garage_input_conditioner_if;
    // No valid/ready handshake here: raw inputs are asynchronous levels, while
    // remote/timer are single-cycle pulses and open/closed are levels, all on clk.
    logic       remote_raw;
    logic       open_raw;
    logic       closed_raw;
    logic       remote;
    logic       open;
    logic       closed;
    logic       timer;
    logic [1:0] dbg_state;

    modport master (
        output remote_raw, open_raw, closed_raw,
        input  remote, open, closed, timer, dbg_state
    );

    modport slave (
        input  remote_raw, open_raw, closed_raw,
        output remote, open, closed, timer, dbg_state
    );
endinterface

// File: rtl/garage_input_conditioner.sv
// Synchronizes/debounces the remote button, synchronizes the limit sensors and
// generates the auto-close timer pulse. Define SENSOR_FILTER_EN for 3-sample sensor filtering.
`timescale 1ns/1ps

module garage_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 1500000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    garage_input_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       remote_sync;
    logic [1:0]       open_sync;
    logic [1:0]       closed_sync;
    logic             remote_s;
    logic             open_s;
    logic             closed_s;

    logic             open_q;
    logic             closed_q;
    logic             remote_q;
    logic             timer_q;

    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;
    logic             remote_d;

    logic [CNT_W-1:0] tcnt_q;
    logic [CNT_W-1:0] tcnt_d;
    logic             fired_q;
    logic             fired_d;
    logic             timer_d;

    assign remote_s = remote_sync[1];
    assign open_s   = open_sync[1];
    assign closed_s = closed_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remote_sync <= 2'b00;
            open_sync   <= 2'b00;
            closed_sync <= 2'b00;
        end else begin
            remote_sync <= {remote_sync[0], bus.remote_raw};
            open_sync   <= {open_sync[0], bus.open_raw};
            closed_sync <= {closed_sync[0], bus.closed_raw};
        end
    end

`ifdef SENSOR_FILTER_EN
    // Output follows a sensor only once three consecutive samples agree.
    logic [1:0] open_hist;
    logic [1:0] closed_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_hist   <= 2'b00;
            closed_hist <= 2'b00;
            open_q      <= 1'b0;
            closed_q    <= 1'b0;
        end else begin
            open_hist   <= {open_hist[0], open_s};
            closed_hist <= {closed_hist[0], closed_s};
            if ((open_s == open_hist[0]) && (open_s == open_hist[1])) begin
                open_q <= open_s;
            end
            if ((closed_s == closed_hist[0]) && (closed_s == closed_hist[1])) begin
                closed_q <= closed_s;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q   <= 1'b0;
            closed_q <= 1'b0;
        end else begin
            open_q   <= open_s;
            closed_q <= closed_s;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dcnt_q   <= '0;
            remote_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            remote_q <= remote_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        remote_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (remote_s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!remote_s) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d  = HELD;
                    remote_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!remote_s) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (remote_s) begin
                    state_d = HELD;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    // A press accepted on this edge restarts the window and beats a terminal count,
    // so remote and timer can never pulse together.
    always_comb begin
        tcnt_d  = tcnt_q;
        fired_d = fired_q;
        timer_d = 1'b0;
        if (!open_q || remote_d) begin
            tcnt_d  = '0;
            fired_d = 1'b0;
        end else if (!fired_q) begin
            if (tcnt_q == TMO_LAST) begin
                timer_d = 1'b1;
                fired_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q  <= '0;
            fired_q <= 1'b0;
            timer_q <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            fired_q <= fired_d;
            timer_q <= timer_d;
        end
    end

    assign bus.remote    = remote_q;
    assign bus.open      = open_q;
    assign bus.closed    = closed_q;
    assign bus.timer     = timer_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_garage_input_conditioner.sv
// Bench for garage_input_conditioner: run-length reference model plus directed latency checks.
`timescale 1ns/1ps

module tb_garage_input_conditioner;
  localparam int D = 4;
  localparam int T = 10;
`ifdef SENSOR_FILTER_EN
  localparam int SENS_LAT = 5;
`else
  localparam int SENS_LAT = 3;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  garage_input_conditioner_if gif ();

  garage_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES(T),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(gif.slave)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw histories (bit 0 = sample at previous edge). A press/release is accepted
  // after D+1 consecutive equal synchronized samples; the timer fires on the T-th
  // consecutive edge with open high and no accepted press.
  logic [4:0] rh, oh, ch;
  logic       m_level, m_prev, m_v, m_pulse;
  int         m_run, m_trun;
  logic       exp_remote, exp_open, exp_closed, exp_timer;
  logic [3:0] exp_q[$];

  function automatic logic sensor_model(input logic [4:0] h, input logic prev);
`ifdef SENSOR_FILTER_EN
    if ((h[1] == h[2]) && (h[2] == h[3])) return h[1];
    return prev;
`else
    return h[1];
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rh = '0; oh = '0; ch = '0;
      m_level = 1'b0; m_prev = 1'b0; m_run = 0; m_trun = 0;
      exp_remote = 1'b0; exp_open = 1'b0; exp_closed = 1'b0; exp_timer = 1'b0;
    end else begin
      m_v = rh[1];
      if (m_v == m_prev) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1;
      end
      m_prev = m_v;
      m_pulse = 1'b0;
      if (!m_level && m_v && m_run == D + 1) begin
        m_level = 1'b1;
        m_pulse = 1'b1;
      end else if (m_level && !m_v && m_run == D + 1) begin
        m_level = 1'b0;
      end
      if (exp_open && !m_pulse) begin
        if (m_trun < 1000) m_trun++;
      end else begin
        m_trun = 0;
      end
      exp_timer  = (m_trun == T);
      exp_remote = m_pulse;
      exp_open   = sensor_model(oh, exp_open);
      exp_closed = sensor_model(ch, exp_closed);
      rh = {rh[3:0], gif.remote_raw};
      oh = {oh[3:0], gif.open_raw};
      ch = {ch[3:0], gif.closed_raw};
    end
    exp_q.push_back({exp_remote, exp_open, exp_closed, exp_timer});
  end

  // ---------------- scoreboard compare ----------------
  logic [3:0] exp_v;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp_v = exp_q.pop_front();
      check("remote", gif.remote, exp_v[3]);
      check("open", gif.open, exp_v[2]);
      check("closed", gif.closed, exp_v[1]);
      check("timer", gif.timer, exp_v[0]);
    end
  end

  // ---------------- driver tasks ----------------
  int w_first_remote, w_n_remote, w_first_timer, w_n_timer;
  int w_first_open, w_first_closed, w_n_closed;

  // Runs n edges; remote_raw is high for tick indices [rem_from, rem_to).
  // Tick i (1-based) observes outputs after edge i.
  task automatic watch(input int n, input int rem_from, input int rem_to);
    w_first_remote = 0; w_n_remote = 0; w_first_timer = 0; w_n_timer = 0;
    w_first_open = 0; w_first_closed = 0; w_n_closed = 0;
    for (int i = 0; i < n; i++) begin
      gif.remote_raw = (i >= rem_from) && (i < rem_to);
      @(negedge clk);
      if (gif.remote) begin w_n_remote++; if (w_first_remote == 0) w_first_remote = i + 1; end
      if (gif.timer) begin w_n_timer++; if (w_first_timer == 0) w_first_timer = i + 1; end
      if (gif.open && w_first_open == 0) w_first_open = i + 1;
      if (gif.closed) begin w_n_closed++; if (w_first_closed == 0) w_first_closed = i + 1; end
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_remote"}, gif.remote, 1'b0);
    check({tag, "_rst_open"}, gif.open, 1'b0);
    check({tag, "_rst_closed"}, gif.closed, 1'b0);
    check({tag, "_rst_timer"}, gif.timer, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] bounce;
  int fr, nr, rem_left, open_left;

  initial begin
    gif.remote_raw = 1'b0; gif.open_raw = 1'b0; gif.closed_raw = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_remote", gif.remote, 1'b0);
    check("reset_open", gif.open, 1'b0);
    check("reset_closed", gif.closed, 1'b0);
    check("reset_timer", gif.timer, 1'b0);

    // clean press held 40 cycles
    rst_n = 1'b1;
    watch(40, 0, 40);
    check_int("t1_first_remote", w_first_remote, 7);
    check_int("t1_remote_count", w_n_remote, 1);
    watch(12, 0, 0);
    check_int("t1_release_pulses", w_n_remote, 0);

    // bouncy press, then a short glitch
    bounce = 9'b111101101;
    fr = 0; nr = 0;
    for (int i = 0; i < 21; i++) begin
      gif.remote_raw = (i < 9) ? bounce[i] : 1'b1;
      @(negedge clk);
      if (gif.remote) begin nr++; if (fr == 0) fr = i + 1; end
    end
    check_int("t2_first_remote", fr, 12);
    check_int("t2_pulses", nr, 1);
    watch(12, 0, 0);
    watch(15, 0, 3);
    check_int("t2_glitch_pulses", w_n_remote, 0);

    // auto-close timeout and re-arm
    gif.open_raw = 1'b1;
    watch(30, 0, 0);
    check_int("t3_open_latency", w_first_open, SENS_LAT);
    check_int("t3_timer_edge", w_first_timer, SENS_LAT + T);
    check_int("t3_timer_count", w_n_timer, 1);
    gif.open_raw = 1'b0;
    watch(5, 0, 0);
    gif.open_raw = 1'b1;
    watch(30, 0, 0);
    check_int("t3_rearm_timer_edge", w_first_timer, SENS_LAT + T);
    check_int("t3_rearm_timer_count", w_n_timer, 1);

    // press inside the open window restarts it
    gif.open_raw = 1'b0;
    watch(10, 0, 0);
    gif.open_raw = 1'b1;
    watch(30, 2, 30);
    check_int("t4_remote_edge", w_first_remote, 9);
    check_int("t4_timer_edge", w_first_timer, 9 + T);
    check_int("t4_timer_count", w_n_timer, 1);
    gif.open_raw = 1'b0;
    watch(12, 0, 0);

    // async reset during PRESS_WAIT
    watch(5, 0, 5);
    async_reset_check("t5a");
    watch(20, 0, 20);
    check_int("t5a_remote_edge", w_first_remote, 7);
    check_int("t5a_remote_count", w_n_remote, 1);
    watch(12, 0, 0);

    // async reset mid-timeout (tcnt = 8)
    gif.open_raw = 1'b1;
    watch(SENS_LAT + 8, 0, 0);
    check("t5b_open_before", gif.open, 1'b1);
    check_int("t5b_no_timer_yet", w_n_timer, 0);
    async_reset_check("t5b");
    watch(30, 0, 0);
    check_int("t5b_open_latency", w_first_open, SENS_LAT);
    check_int("t5b_timer_edge", w_first_timer, SENS_LAT + T);

    // closed sensor glitch and sustained change
    gif.open_raw = 1'b0;
    watch(10, 0, 0);
    gif.closed_raw = 1'b1;
    @(negedge clk);
    gif.closed_raw = 1'b0;
    watch(10, 0, 0);
`ifdef SENSOR_FILTER_EN
    check_int("t6_glitch_closed_cycles", w_n_closed, 0);
`else
    check_int("t6_glitch_closed_cycles", w_n_closed, 1);
`endif
    gif.closed_raw = 1'b1;
    watch(12, 0, 0);
    check_int("t6_closed_latency", w_first_closed, SENS_LAT);

    // randomized traffic against the model
    rem_left = 0; open_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (rem_left == 0) begin
        gif.remote_raw = ~gif.remote_raw;
        rem_left = $urandom_range(1, 9);
      end
      rem_left--;
      if (open_left == 0) begin
        gif.open_raw = ~gif.open_raw;
        open_left = $urandom_range(1, 35);
      end
      open_left--;
      if ($urandom_range(0, 5) == 0) gif.closed_raw = ~gif.closed_raw;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
